cordic_gain_comp: RTL
=====================

Name: cordic_gain_comp

Overview:
- Downstream stage of the iterative CORDIC rotation core.
- Tracks the core's iteration count from a start pulse and captures the core's x/y/z registers once the last micro-rotation completes.
- Removes the CORDIC gain from x and y with a serial shift-add multiply by K = 0.6072529350; z is not scaled.
- Presents the result on a valid/ready output handshake.

Parameters:
- BIT_WIDTH, 64: width of x/y/z data. Signed two's complement, same format as the core.
- ITERATIONS, 16: number of core micro-rotations before capture. Range 1..63 (core counter is 6-bit).
- KW, 16: fractional bits of the gain constant. Gain constant is unsigned Q0.KW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  pulse in the cycle the core loads its initial x/y/z.
- x_in  in  BIT_WIDTH  core x_output.
- y_in  in  BIT_WIDTH  core y_output.
- z_in  in  BIT_WIDTH  core z_output.
- busy  out  1  high in WAIT and SCALE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- x_out  out  BIT_WIDTH  gain-compensated x.
- y_out  out  BIT_WIDTH  gain-compensated y.
- z_out  out  BIT_WIDTH  residual angle, unscaled.

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE. Counters clear.
  - busy=0, out_valid=0; x_out, y_out, z_out all zero.
  - Reset asserted in any state aborts the operation immediately; the partial result is discarded.
- States:
  - IDLE: wait for start.
  - WAIT: iteration counter cnt (6-bit) runs.
  - SCALE: serial multiply, bit counter kcnt.
  - DONE: out_valid held high.
- IDLE -> WAIT: on start=1 at edge E0; cnt<=0.
- WAIT: cnt increments each edge.
  - At the edge where cnt==ITERATIONS, capture x_in, y_in, z_in into working registers; go to SCALE with kcnt<=0 and accumulators cleared.
  - The capture edge is E(ITERATIONS).
- SCALE: one step per edge, K bits processed MSB first.
  - Step: acc <= (acc<<1) + (K[KW-1-kcnt] ? sign-extended operand : 0).
  - Accumulators are BIT_WIDTH+KW bits, signed.
  - After KW steps, ending at edge E(ITERATIONS+KW):
    - x_out = acc_x[BIT_WIDTH+KW-1:KW]; y_out likewise.
    - Result is an arithmetic right shift, truncation toward minus infinity. No rounding.
    - z_out = captured z.
    - out_valid<=1; go to DONE.
- Overflow: none possible, since K<1. No saturation logic.
- DONE:
  - x_out, y_out, z_out and out_valid stay stable until out_valid && out_ready at an edge.
  - On acceptance, go to IDLE and clear out_valid. Output data keeps its last value.
  - start and accept in the same cycle: go directly to WAIT (back-to-back), cnt<=0, out_valid<=0.
- start while in WAIT or SCALE: ignored. The running operation continues unaffected.
- start while in DONE without acceptance: ignored.
- out_ready while not out_valid: no effect.
- Latency: out_valid is first high in the cycle after edge E(ITERATIONS+KW), i.e. ITERATIONS+KW cycles after the start edge.
- Throughput: one result per ITERATIONS+KW+1 cycles with out_ready tied high.
- busy: high exactly in WAIT and SCALE.

Decomposition:
- Package cordic_pkg holds:
  - CORDIC_K_INV_Q16 = 16'h9B75, i.e. round(0.6072529350 * 2^16).
  - State enum {IDLE, WAIT, SCALE, DONE}.
  - Default ITERATIONS.
- For KW other than 16, the constant is derived in the package.
- One sub-module, serial_const_mult, parameterised on BIT_WIDTH and KW. It takes an operand, load, step and the constant, and produces the product. It is instantiated twice, once for x and once for y.

Test Plan (BIT_WIDTH=32, ITERATIONS=16, KW=16):
- Nominal: start at E0 with x_in=32'h0001_0000, y_in=0, z_in=32'h0000_0123 held through capture.
  - x_out=32'h0000_9B75, y_out=0, z_out=32'h0000_0123.
  - out_valid first high after E32; busy high E1..E32.
- Signs/truncation: captured values map as follows.
  - x=32'hFFFF_0000 -> x_out=32'hFFFF_648B.
  - x=1 -> x_out=0.
  - y=32'hFFFF_FFFF -> y_out=32'hFFFF_FFFF.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - Outputs stable, out_valid stays high.
  - start pulses in that window are ignored.
  - out_ready=1 -> IDLE next edge.
- Back-to-back: start and out_ready both high in the first DONE cycle.
  - Second result valid exactly 32 cycles later, with its own captured data.
- Reset mid-SCALE: rst=1 at E20.
  - Next cycle busy=0, out_valid=0, outputs zero.
  - No out_valid appears without a new start.
- Capture alignment: x_in changed every cycle to the cycle index.
  - x_out equals scaled value 16 (the x_in sampled at E16) -> 16*0x9B75>>16 = 9.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, FSM state type and gain-constant helper
// for the CORDIC gain-compensation stage.
package cordic_pkg;

  localparam int CORDIC_ITERATIONS = 16;

  // 1/K = 0.6072529350 as unsigned Q0.16 and Q0.32
  localparam logic [15:0] CORDIC_K_INV_Q16 = 16'h9B75;
  localparam logic [31:0] CORDIC_K_INV_Q32 = 32'h9B74_EDA8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SCALE,
    DONE
  } state_e;

  // Gain constant as Q0.kw (1 <= kw <= 32), rounded from Q0.32
  function automatic logic [31:0] k_inv(input int kw);
    logic [32:0] t;
    if (kw == 16) return {16'h0, CORDIC_K_INV_Q16};
    t = {1'b0, CORDIC_K_INV_Q32};
    if (kw < 32) t = t + (33'd1 << (31 - kw));
    t = t >> (32 - kw);
    return t[31:0];
  endfunction

endpackage

// File: rtl/cordic_gain_comp_mult.sv
// serial_const_mult: MSB-first shift-add multiply of a signed operand by
// an unsigned Q0.KW constant, one constant bit per step.
// Ports: clk, rst (sync), load (capture operand/constant, clear acc),
//   step (one shift-add), operand, k, product_d (acc after this edge >> KW).
module serial_const_mult #(
  parameter int BIT_WIDTH = 64,
  parameter int KW        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [BIT_WIDTH-1:0] operand,
  input  logic [KW-1:0]        k,
  output logic [BIT_WIDTH-1:0] product_d
);

  localparam int AW = BIT_WIDTH + KW;

  logic [BIT_WIDTH-1:0] op_q, op_d;
  logic [KW-1:0]        k_q, k_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        op_ext;
  logic [AW-1:0]        addend;

  assign op_ext = {{KW{op_q[BIT_WIDTH-1]}}, op_q};
  // constant is shifted left each step so its MSB is the current bit
  assign addend = k_q[KW-1] ? op_ext : '0;

  always_comb begin
    op_d  = op_q;
    k_d   = k_q;
    acc_d = acc_q;
    if (load) begin
      op_d  = operand;
      k_d   = k;
      acc_d = '0;
    end else if (step) begin
      acc_d = {acc_q[AW-2:0], 1'b0} + addend;
      k_d   = k_q << 1;
    end
  end

  // upper slice = arithmetic shift right by KW (floor)
  assign product_d = acc_d[AW-1:KW];

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      k_q   <= '0;
      acc_q <= '0;
    end else begin
      op_q  <= op_d;
      k_q   <= k_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: waits out the CORDIC core iterations, captures x/y/z,
// scales x/y by 1/K serially and presents the result on valid/ready.
// Ports: clk, rst (sync, active-high), start, x_in/y_in/z_in (core regs),
//   busy, out_valid, out_ready, x_out/y_out (scaled), z_out (unscaled).
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH  = 64,
  parameter int ITERATIONS = CORDIC_ITERATIONS,
  parameter int KW         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic [BIT_WIDTH-1:0] y_in,
  input  logic [BIT_WIDTH-1:0] z_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] x_out,
  output logic [BIT_WIDTH-1:0] y_out,
  output logic [BIT_WIDTH-1:0] z_out
);

  localparam logic [KW-1:0] K_CONST  = KW'(k_inv(KW));
  localparam logic [5:0]    CNT_LAST = 6'(ITERATIONS - 1);
  localparam logic [5:0]    K_LAST   = 6'(KW - 1);

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [5:0]           kcnt_q, kcnt_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [BIT_WIDTH-1:0] z_cap_q, z_cap_d;
  logic [BIT_WIDTH-1:0] x_out_q, x_out_d;
  logic [BIT_WIDTH-1:0] y_out_q, y_out_d;
  logic [BIT_WIDTH-1:0] z_out_q, z_out_d;
  logic [BIT_WIDTH-1:0] x_prod_d, y_prod_d;

  logic capture;
  logic step;
  logic last_step;
  logic accept;

  // cnt reaches ITERATIONS on the capture edge
  assign capture   = (state_q == WAIT) && (cnt_q == CNT_LAST);
  assign step      = (state_q == SCALE);
  assign last_step = step && (kcnt_q == K_LAST);
  assign accept    = valid_q && out_ready;

  serial_const_mult #(
    .BIT_WIDTH(BIT_WIDTH),
    .KW       (KW)
  ) u_mult_x (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .step     (step),
    .operand  (x_in),
    .k        (K_CONST),
    .product_d(x_prod_d)
  );

  serial_const_mult #(
    .BIT_WIDTH(BIT_WIDTH),
    .KW       (KW)
  ) u_mult_y (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .step     (step),
    .operand  (y_in),
    .k        (K_CONST),
    .product_d(y_prod_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kcnt_d  = kcnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    z_cap_d = z_cap_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 6'd1;
        if (capture) begin
          state_d = SCALE;
          kcnt_d  = '0;
          z_cap_d = z_in;
        end
      end
      SCALE: begin
        kcnt_d = kcnt_q + 6'd1;
        if (last_step) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          x_out_d = x_prod_d;
          y_out_d = y_prod_d;
          z_out_d = z_cap_q;
        end
      end
      DONE: begin
        if (accept) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = WAIT;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kcnt_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      z_cap_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kcnt_q  <= kcnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      z_cap_q <= z_cap_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

endmodule
